// File: rtl/boreal_dma_desc_queue_pkg.sv
// Shared definitions for the DMA descriptor submission queue: register map,
// STATUS field layout and the descriptor record.
package boreal_dma_desc_queue_pkg;

  localparam logic [7:0] DQ_OFF_SRC    = 8'h00;
  localparam logic [7:0] DQ_OFF_DST    = 8'h04;
  localparam logic [7:0] DQ_OFF_LEN    = 8'h08;
  localparam logic [7:0] DQ_OFF_PUSH   = 8'h0C;
  localparam logic [7:0] DQ_OFF_STATUS = 8'h10;
  localparam logic [7:0] DQ_OFF_CTRL   = 8'h14;

  // STATUS bit positions relative to DEPTH_LOG; count occupies [DEPTH_LOG:0].
  localparam int unsigned DQ_ST_EMPTY_REL = 1;
  localparam int unsigned DQ_ST_FULL_REL  = 2;
  localparam int unsigned DQ_ST_OVF_REL   = 3;
  localparam int unsigned DQ_ST_LERR_REL  = 4;
  localparam int unsigned DQ_ST_IRQ_REL   = 5;
  localparam int unsigned DQ_ST_INFL_REL  = 6;

  localparam int unsigned DQ_INFL_W = 5;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } dq_desc_t;

endpackage

// File: rtl/boreal_dma_desc_queue_if.sv
// MMIO, descriptor handshake and completion signals of the descriptor queue.
interface boreal_dma_desc_queue_if;
  logic        sel;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_src;
  logic [31:0] desc_dst;
  logic [31:0] desc_len;
  logic        desc_done;
  logic        irq;

  modport slave (
    input  sel, wr, addr, wdata, desc_ready, desc_done,
    output rdata, ack, desc_valid, desc_src, desc_dst, desc_len, irq
  );

  modport master (
    output sel, wr, addr, wdata, desc_ready, desc_done,
    input  rdata, ack, desc_valid, desc_src, desc_dst, desc_len, irq
  );
endinterface

// File: rtl/boreal_desc_fifo.sv
// First-word-fall-through descriptor FIFO; illegal push/pop requests are ignored
// and flush wins over both.
module boreal_desc_fifo
  import boreal_dma_desc_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  dq_desc_t             wdata,
  output dq_desc_t             rdata,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);

  dq_desc_t               mem_q [DEPTH];
  logic [DEPTH_LOG-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]     count_q;
  logic                   push_ok, pop_ok;

  assign full    = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{DEPTH_LOG{1'b0}}, push_ok} - {{DEPTH_LOG{1'b0}}, pop_ok};
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/boreal_dma_desc_queue.sv
// Descriptor submission queue: MMIO staging and push, FWFT head to the DMA
// engine, in-flight tracking and a sticky completion interrupt.
module boreal_dma_desc_queue
  import boreal_dma_desc_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DEPTH_LOG = 4
) (
  input logic                   clk,
  input logic                   rst,
  boreal_dma_desc_queue_if.slave bus
);

  localparam int unsigned StEmpty = DEPTH_LOG + DQ_ST_EMPTY_REL;
  localparam int unsigned StFull  = DEPTH_LOG + DQ_ST_FULL_REL;
  localparam int unsigned StOvf   = DEPTH_LOG + DQ_ST_OVF_REL;
  localparam int unsigned StLerr  = DEPTH_LOG + DQ_ST_LERR_REL;
  localparam int unsigned StIrq   = DEPTH_LOG + DQ_ST_IRQ_REL;
  localparam int unsigned StInfl  = DEPTH_LOG + DQ_ST_INFL_REL;

  logic [31:0]          src_q, dst_q, len_q;
  logic                 irq_en_q;
  logic                 overflow_q, overflow_d;
  logic                 len_err_q, len_err_d;
  logic                 irq_pending_q, irq_pending_d;
  logic [DQ_INFL_W-1:0] inflight_q, inflight_d;

  logic [7:0]           reg_off;
  logic                 wr_en, push_req, flush, st_wr;
  logic                 push_fire, pop_fire, ovf_set, lerr_set, irq_set;
  logic [DEPTH_LOG:0]   count;
  logic                 full, empty;
  dq_desc_t             head;
  logic [31:0]          status, rdata;
  logic                 unused_addr;

  assign unused_addr = ^bus.addr[31:8];
  assign reg_off     = bus.addr[7:0];
  assign wr_en       = bus.sel & bus.wr;
  assign push_req    = wr_en & (reg_off == DQ_OFF_PUSH) & bus.wdata[0];
  assign flush       = wr_en & (reg_off == DQ_OFF_CTRL) & bus.wdata[1];
  assign st_wr       = wr_en & (reg_off == DQ_OFF_STATUS);

  // A full queue rejects a push even when the head leaves in the same cycle.
  assign ovf_set   = push_req & full & ~flush;
  assign lerr_set  = push_req & ~full & (len_q == '0) & ~flush;
  assign push_fire = push_req & ~full & (len_q != '0) & ~flush;
  assign pop_fire  = ~empty & bus.desc_ready & ~flush;
  assign irq_set   = bus.desc_done & (inflight_q == 5'd1) & empty & ~pop_fire;

  boreal_desc_fifo #(
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire),
    .pop   (pop_fire),
    .flush (flush),
    .wdata ({src_q, dst_q, len_q}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    overflow_d    = (overflow_q    & ~(st_wr & bus.wdata[StOvf]))  | ovf_set;
    len_err_d     = (len_err_q     & ~(st_wr & bus.wdata[StLerr])) | lerr_set;
    irq_pending_d = (irq_pending_q & ~(st_wr & bus.wdata[StIrq]))  | irq_set;

    inflight_d = inflight_q;
    if (pop_fire && !bus.desc_done) begin
      if (inflight_q != 5'd31) inflight_d = inflight_q + 5'd1;
    end else if (!pop_fire && bus.desc_done && inflight_q != '0) begin
      inflight_d = inflight_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      irq_en_q      <= 1'b0;
      overflow_q    <= 1'b0;
      len_err_q     <= 1'b0;
      irq_pending_q <= 1'b0;
      inflight_q    <= '0;
    end else begin
      if (wr_en && reg_off == DQ_OFF_SRC)  src_q    <= bus.wdata;
      if (wr_en && reg_off == DQ_OFF_DST)  dst_q    <= bus.wdata;
      if (wr_en && reg_off == DQ_OFF_LEN)  len_q    <= bus.wdata;
      if (wr_en && reg_off == DQ_OFF_CTRL) irq_en_q <= bus.wdata[0];
      overflow_q    <= overflow_d;
      len_err_q     <= len_err_d;
      irq_pending_q <= irq_pending_d;
      inflight_q    <= inflight_d;
    end
  end

  always_comb begin
    status                      = '0;
    status[DEPTH_LOG:0]         = count;
    status[StEmpty]             = empty;
    status[StFull]              = full;
    status[StOvf]               = overflow_q;
    status[StLerr]              = len_err_q;
    status[StIrq]               = irq_pending_q;
    status[StInfl +: DQ_INFL_W] = inflight_q;
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      DQ_OFF_SRC:    rdata = src_q;
      DQ_OFF_DST:    rdata = dst_q;
      DQ_OFF_LEN:    rdata = len_q;
      DQ_OFF_STATUS: rdata = status;
      DQ_OFF_CTRL:   rdata = {31'b0, irq_en_q};
      default:       rdata = '0;
    endcase
  end

  assign bus.rdata      = rdata;
  assign bus.ack        = bus.sel;
  assign bus.desc_valid = ~empty;
  assign bus.desc_src   = head.src;
  assign bus.desc_dst   = head.dst;
  assign bus.desc_len   = head.len;
  assign bus.irq        = irq_pending_q & irq_en_q;

endmodule
